// File: rtl/text_line_renderer_pkg.sv
// Glyph geometry defines and shared types for the text line renderer.
// Optional wrap at a box width is enabled by defining TEXT_WRAP_EN.
`ifndef TEXT_LINE_RENDERER_DEFINES
`define TEXT_LINE_RENDERER_DEFINES
`define CHAR_BITES   8
`define X_BITES      8
`define Y_BITES      8
`define SQUARE_BITES 3
`define FONT_WIDTH   5
`define FONT_HEIGHT  7
`endif

package text_line_renderer_pkg;
   localparam int unsigned CHAR_W = `CHAR_BITES;
   localparam int unsigned X_W    = `X_BITES;
   localparam int unsigned Y_W    = `Y_BITES;
   localparam int unsigned SQ_W   = `SQUARE_BITES;
   localparam int unsigned CELL_W = `FONT_WIDTH + 1;
   localparam int unsigned CELL_H = `FONT_HEIGHT + 1;

   // Payload presented to the character renderer for one glyph.
   typedef struct packed {
      logic [CHAR_W-1:0] code;
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
   } glyph_t;
endpackage

// File: rtl/text_line_renderer_cursor.sv
// Text cursor: origin, pitch and current position with advance/newline controls.
module text_cursor
   import text_line_renderer_pkg::*;
(
   input  logic            clock,
   input  logic            resetn,
   input  logic            i_load,
   input  logic [X_W-1:0]  i_origin_x,
   input  logic [Y_W-1:0]  i_origin_y,
   input  logic [SQ_W-1:0] i_size,
   input  logic            i_newline,
   input  logic            i_advance,
   output logic [X_W-1:0]  o_cur_x,
   output logic [Y_W-1:0]  o_cur_y,
   output logic [X_W-1:0]  o_pitch_x,
   output logic [Y_W-1:0]  o_pitch_y,
   output logic [X_W-1:0]  o_origin_x
);
   logic [X_W-1:0] r_cur_x, r_pitch_x, r_org_x;
   logic [Y_W-1:0] r_cur_y, r_pitch_y;
   logic [X_W-1:0] w_base_x;

   // Newline and advance may combine: a wrapped space lands one pitch past the origin.
   assign w_base_x = i_newline ? r_org_x : r_cur_x;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cur_x   <= '0;
         r_cur_y   <= '0;
         r_pitch_x <= '0;
         r_pitch_y <= '0;
         r_org_x   <= '0;
      end else if (i_load) begin
         r_org_x   <= i_origin_x;
         r_cur_x   <= i_origin_x;
         r_cur_y   <= i_origin_y;
         r_pitch_x <= X_W'(32'(i_size) * CELL_W);
         r_pitch_y <= Y_W'(32'(i_size) * CELL_H);
      end else begin
         if (i_newline || i_advance)
            r_cur_x <= w_base_x + (i_advance ? r_pitch_x : '0);
         if (i_newline)
            r_cur_y <= r_cur_y + r_pitch_y;
      end
   end

   assign o_cur_x    = r_cur_x;
   assign o_cur_y    = r_cur_y;
   assign o_pitch_x  = r_pitch_x;
   assign o_pitch_y  = r_pitch_y;
   assign o_origin_x = r_org_x;
endmodule

// File: rtl/text_line_renderer.sv
// Walks a string in the text buffer and feeds the character renderer glyph by glyph.
// Define TEXT_WRAP_EN to wrap at box_width; otherwise glyphs overrunning the X range are skipped.
module text_line_renderer
   import text_line_renderer_pkg::*;
#(
   parameter int unsigned             ADDR_W       = 6,
   parameter logic [`CHAR_BITES-1:0]  NEWLINE_CODE = 8'h0A,
   parameter logic [`CHAR_BITES-1:0]  SPACE_CODE   = 8'h20
)(
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        length,
   input  logic [`X_BITES-1:0]      origin_x,
   input  logic [`Y_BITES-1:0]      origin_y,
   input  logic [`SQUARE_BITES-1:0] size,
   input  logic [`X_BITES-1:0]      box_width,
   output logic [ADDR_W-1:0]        text_addr,
   input  logic [`CHAR_BITES-1:0]   text_data,
   output logic [`CHAR_BITES-1:0]   char_code,
   output logic [`X_BITES-1:0]      char_x,
   output logic [`Y_BITES-1:0]      char_y,
   output logic                     char_enable,
   input  logic                     char_finished,
   output logic                     busy,
   output logic                     done
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_DATA, S_DRAW, S_RELEASE, S_NEXT, S_FINISH
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt, r_len, w_len_nxt, r_addr, w_addr_nxt;
   glyph_t            r_glyph, w_glyph_nxt;
   logic              r_enable, r_busy, r_done;
   logic              r_first, w_first_nxt, r_rel, w_rel_nxt;
   logic              w_load, w_newline, w_advance;
   logic [X_W-1:0]    w_cur_x, w_pitch_x, w_org_x;
   logic [Y_W-1:0]    w_cur_y, w_pitch_y;
   logic [X_W:0]      w_end_x, w_limit_x;
   logic              w_overflow;

   text_cursor u_cursor (
      .clock      (clock),
      .resetn     (resetn),
      .i_load     (w_load),
      .i_origin_x (origin_x),
      .i_origin_y (origin_y),
      .i_size     (size),
      .i_newline  (w_newline),
      .i_advance  (w_advance),
      .o_cur_x    (w_cur_x),
      .o_cur_y    (w_cur_y),
      .o_pitch_x  (w_pitch_x),
      .o_pitch_y  (w_pitch_y),
      .o_origin_x (w_org_x)
   );

   assign w_end_x = {1'b0, w_cur_x} + {1'b0, w_pitch_x};

`ifdef TEXT_WRAP_EN
   logic [X_W-1:0] r_box;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)     r_box <= '0;
      else if (w_load) r_box <= box_width;
   end

   assign w_limit_x = {1'b0, w_org_x} + {1'b0, r_box};
`else
   logic w_unused_sink;

   assign w_unused_sink = ^{box_width, w_org_x, w_pitch_y};
   assign w_limit_x     = (X_W+1)'(1 << X_W);
`endif

   assign w_overflow = (w_end_x > w_limit_x);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state plus next values of every registered output.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_len_nxt   = r_len;
      w_addr_nxt  = r_addr;
      w_glyph_nxt = r_glyph;
      w_first_nxt = 1'b0;
      w_rel_nxt   = r_rel;
      w_load      = 1'b0;
      w_newline   = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_len_nxt   = length;
               w_idx_nxt   = '0;
               w_state_nxt = (length == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH: w_state_nxt = S_WAIT_DATA;
         S_WAIT_DATA: begin
            w_glyph_nxt.code = text_data;
            if (text_data == NEWLINE_CODE) begin
               w_newline   = 1'b1;
               w_state_nxt = S_NEXT;
            end else if (text_data == SPACE_CODE) begin
               w_advance   = 1'b1;
`ifdef TEXT_WRAP_EN
               w_newline   = w_overflow;
`endif
               w_state_nxt = S_NEXT;
            end else begin
`ifdef TEXT_WRAP_EN
               w_newline     = w_overflow;
               w_glyph_nxt.x = w_overflow ? w_org_x : w_cur_x;
               w_glyph_nxt.y = w_overflow ? (w_cur_y + w_pitch_y) : w_cur_y;
               w_first_nxt   = 1'b1;
               w_state_nxt   = S_DRAW;
`else
               if (w_overflow) begin
                  w_advance   = 1'b1;
                  w_state_nxt = S_NEXT;
               end else begin
                  w_glyph_nxt.x = w_cur_x;
                  w_glyph_nxt.y = w_cur_y;
                  w_first_nxt   = 1'b1;
                  w_state_nxt   = S_DRAW;
               end
`endif
            end
         end
         S_DRAW: begin
            if (!r_first && char_finished) begin
               w_rel_nxt   = 1'b0;
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!r_rel) begin
               w_rel_nxt = 1'b1;
            end else begin
               w_advance   = 1'b1;
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            w_idx_nxt   = r_idx + ADDR_W'(1);
            w_state_nxt = (w_idx_nxt == r_len) ? S_FINISH : S_FETCH;
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt == S_FETCH)
         w_addr_nxt = w_idx_nxt;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_idx    <= '0;
         r_len    <= '0;
         r_addr   <= '0;
         r_glyph  <= '0;
         r_first  <= 1'b0;
         r_rel    <= 1'b0;
         r_enable <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_idx    <= w_idx_nxt;
         r_len    <= w_len_nxt;
         r_addr   <= w_addr_nxt;
         r_glyph  <= w_glyph_nxt;
         r_first  <= w_first_nxt;
         r_rel    <= w_rel_nxt;
         r_enable <= (w_state_nxt == S_DRAW);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= (w_state_nxt == S_FINISH);
      end
   end

   assign text_addr   = r_addr;
   assign char_code   = r_glyph.code;
   assign char_x      = r_glyph.x;
   assign char_y      = r_glyph.y;
   assign char_enable = r_enable;
   assign busy        = r_busy;
   assign done        = r_done;
endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer: string-level glyph model, buffer and renderer models.
module tb_text_line_renderer;
   localparam int unsigned AW = 6;

   logic          clock = 1'b0;
   logic          resetn;
   logic          start = 1'b0;
   logic [AW-1:0] length = '0;
   logic [7:0]    origin_x = '0, origin_y = '0, box_width = '0;
   logic [2:0]    size = '0;
   logic [AW-1:0] text_addr;
   logic [7:0]    text_data = '0;
   logic [7:0]    char_code, char_x, char_y;
   logic          char_enable, char_finished, busy, done;

   text_line_renderer dut (
      .clock(clock), .resetn(resetn), .start(start), .length(length),
      .origin_x(origin_x), .origin_y(origin_y), .size(size), .box_width(box_width),
      .text_addr(text_addr), .text_data(text_data), .char_code(char_code),
      .char_x(char_x), .char_y(char_y), .char_enable(char_enable),
      .char_finished(char_finished), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct { int code; int x; int y; } g_t;
   g_t         expq[$];
   g_t         held;
   logic [7:0] mem [0:63];
   int         total = 0, bad = 0;
   int         rises = 0, dones = 0, en_cycles = 0, rend_time = 3, rcnt = 0;
   logic       prev_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Synchronous-read text buffer.
   always @(posedge clock) text_data <= mem[text_addr];

   // Renderer: raises finished once enable has been high rend_time cycles, clears when released.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rcnt <= 0;
         char_finished <= 1'b0;
      end else if (char_enable) begin
         rcnt <= rcnt + 1;
         char_finished <= (rcnt + 1 >= rend_time);
      end else begin
         rcnt <= 0;
         char_finished <= 1'b0;
      end
   end

   // Expected glyph list from the string-level cursor rules.
   task automatic build_model(input string s, input int ox, input int oy, input int sz, input int bw);
      int px, py, cx, cy, c;
      bit ovf;
      px = (sz * 6) % 256;
      py = (sz * 8) % 256;
      cx = ox;
      cy = oy;
      expq.delete();
      for (int i = 0; i < s.len(); i++) begin
         c = int'(s[i]);
`ifdef TEXT_WRAP_EN
         ovf = (cx + px > ox + bw);
`else
         ovf = (cx + px > 256);
`endif
         if (c == 10) begin
            cx = ox;
            cy = (cy + py) % 256;
         end else begin
`ifdef TEXT_WRAP_EN
            if (ovf) begin
               cx = ox;
               cy = (cy + py) % 256;
            end
            if (c != 32) expq.push_back('{c, cx, cy});
`else
            if (c != 32 && !ovf) expq.push_back('{c, cx, cy});
`endif
            cx = (cx + px) % 256;
         end
      end
   endtask

   // Compare process: glyph payload at each enable rise, stability while enabled, done/busy relation.
   always @(negedge clock) begin
      if (char_enable) begin
         en_cycles++;
         chk("enable_implies_busy", busy, 1);
         if (!prev_en) begin
            rises++;
            if (expq.size() == 0) begin
               chk("glyph_unexpected", 1, 0);
            end else begin
               chk("glyph_code", char_code, expq[0].code);
               chk("glyph_x", char_x, expq[0].x);
               chk("glyph_y", char_y, expq[0].y);
               void'(expq.pop_front());
            end
            held = '{int'(char_code), int'(char_x), int'(char_y)};
         end else begin
            chk("glyph_stable", {char_code, char_x, char_y},
                {8'(held.code), 8'(held.x), 8'(held.y)});
         end
      end
      if (done) begin
         dones++;
         chk("busy_at_done", busy, 1);
      end
      prev_en = char_enable;
   end

   task automatic run_case(input string nm, input string s, input int ox, input int oy,
                           input int sz, input int bw, input int rt, input bit repulse);
      int cyc, ndraw;
      for (int i = 0; i < s.len(); i++) mem[i] = s[i];
      build_model(s, ox, oy, sz, bw);
      ndraw = expq.size();
      rend_time = rt;
      @(negedge clock);
      rises = 0; dones = 0; en_cycles = 0;
      length = AW'(s.len());
      origin_x = 8'(ox); origin_y = 8'(oy); size = 3'(sz); box_width = 8'(bw);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 3000) begin
         if (repulse && cyc == 8) begin
            start = 1'b1; origin_x = 8'd77; length = AW'(1);
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      chk({nm, "_done_seen"}, done, 1);
      chk({nm, "_latency"}, cyc, 3 * (s.len() - ndraw) + en_cycles + 5 * ndraw + 1);
      start = 1'b1;
      length = AW'(1);
      @(negedge clock);
      start = 1'b0;
      chk({nm, "_busy_after_done"}, busy, 0);
      chk({nm, "_done_one_cycle"}, done, 0);
      repeat (3) @(negedge clock);
      chk({nm, "_start_in_finish_ignored"}, busy, 0);
      chk({nm, "_done_pulses"}, dones, 1);
      chk({nm, "_enable_rises"}, rises, ndraw);
      chk({nm, "_glyphs_left"}, expq.size(), 0);
   endtask

   initial begin
      logic [AW-1:0] saved_addr;
      int k;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_enable", char_enable, 0);
      chk("rst_addr", text_addr, 0);
      chk("rst_code", char_code, 0);
      chk("rst_xy", {char_x, char_y}, 0);

      build_model("HI", 10, 20, 2, 0);
      chk("pin_hi_n", expq.size(), 2);
      chk("pin_hi_a", {expq[0].x, expq[0].y}, {32'd10, 32'd20});
      chk("pin_hi_b", {expq[1].x, expq[1].y}, {32'd22, 32'd20});
      build_model("A\nB", 10, 20, 2, 0);
      chk("pin_nl_b", {expq[1].code, expq[1].x, expq[1].y}, {32'd66, 32'd10, 32'd36});
`ifdef TEXT_WRAP_EN
      build_model("ABC", 0, 0, 2, 24);
      chk("pin_wrap_b", {expq[1].x, expq[1].y}, {32'd12, 32'd0});
      chk("pin_wrap_c", {expq[2].x, expq[2].y}, {32'd0, 32'd16});
`else
      build_model("ABC", 236, 20, 2, 0);
      chk("pin_skip_n", expq.size(), 2);
      chk("pin_skip_c", {expq[1].code, expq[1].x}, {32'd67, 32'd4});
`endif
      expq.delete();

      repeat (2) @(negedge clock);
      resetn = 1'b1;

      run_case("hi", "HI", 10, 20, 2, 0, 3, 1'b0);
      run_case("newline", "A\nB", 10, 20, 2, 0, 1, 1'b0);
      saved_addr = text_addr;
      run_case("zero", "", 10, 20, 2, 0, 3, 1'b0);
      chk("zero_addr_unchanged", text_addr, saved_addr);
      run_case("space_repulse", " X", 10, 20, 2, 0, 6, 1'b1);

      // Abort mid-draw with an asynchronous reset.
      mem[0] = "H"; mem[1] = "I";
      rend_time = 20;
      @(negedge clock);
      length = AW'(2); origin_x = 8'd10; origin_y = 8'd20; size = 3'd2;
      build_model("HI", 10, 20, 2, 0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (char_enable !== 1'b1 && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk("rst_mid_enable_seen", char_enable, 1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_enable", char_enable, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      expq.delete();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      run_case("after_reset", "HI", 10, 20, 2, 0, 3, 1'b0);

      run_case("wrap_abc", "ABC", 0, 0, 2, 24, 2, 1'b0);
      run_case("x_edge", "ABC", 236, 20, 2, 24, 2, 1'b0);
      run_case("y_modulo", "A\nB", 200, 250, 7, 0, 4, 1'b0);
      run_case("space_wrap", "AB C", 0, 20, 2, 30, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
